wb_scoreboard: RTL

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - timed writeback/PC expectation checker with score and optional fail log
// Optional fail-index FIFO: define WB_SCOREBOARD_FAILLOG_EN.
module wb_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 16,
    parameter int MAX_SCORE  = 60,
    parameter int FAIL_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_addr,
    input  logic [7:0]                    cfg_gap,
    input  logic [1:0]                    cfg_kind,
    input  logic [XLEN-1:0]               cfg_exp_data,
    input  logic [XLEN-1:0]               cfg_exp_pc,
    input  logic [7:0]                    cfg_penalty,
    input  logic [$clog2(NUM_CHECKS):0]   cfg_num,
    input  logic                          start,
    input  logic [XLEN-1:0]               wb_data,
    input  logic [XLEN-1:0]               pc,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   score,
    output logic [7:0]                    fail_count,
    output logic                          fail_valid,
    output logic [$clog2(NUM_CHECKS)-1:0] fail_idx,
    input  logic                          fail_pop
);

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int NW = IW + 1;
    localparam logic [NW-1:0] NUM_MAX    = NW'(NUM_CHECKS);
    localparam logic [15:0]   SCORE_INIT = 16'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [7:0]        gap_cnt;
    logic [NW-1:0]     num_lat;

    logic [7:0]        gap_tab  [NUM_CHECKS];
    logic [1:0]        kind_tab [NUM_CHECKS];
    logic [XLEN-1:0]   data_tab [NUM_CHECKS];
    logic [XLEN-1:0]   pc_tab   [NUM_CHECKS];
    logic [7:0]        pen_tab  [NUM_CHECKS];

    function automatic logic [7:0] gap_load(input logic [7:0] g);
        return (g == 8'd0) ? 8'd1 : g;
    endfunction

    logic          cfg_open;
    logic          start_ok;
    logic [NW-1:0] num_clamped;
    logic [IW-1:0] idx_inc;
    logic [7:0]    gap_first;
    logic [7:0]    gap_next;
    logic [1:0]    cur_kind;
    logic [7:0]    cur_pen;
    logic          last;
    logic          miss;

    assign cfg_open    = (state == IDLE) || (state == DONE);
    assign start_ok    = start && cfg_open;
    assign num_clamped = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
    assign idx_inc     = idx + 1'b1;
    assign gap_first   = gap_load(gap_tab[0]);
    assign gap_next    = gap_load(gap_tab[idx_inc]);
    assign cur_kind    = kind_tab[idx];
    assign cur_pen     = pen_tab[idx];
    assign last        = ({1'b0, idx} == (num_lat - NW'(1)));
    assign miss        = (state == CHECK) &&
                         ((cur_kind[0] && (wb_data != data_tab[idx])) ||
                          (cur_kind[1] && (pc != pc_tab[idx])));

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (cfg_we && cfg_open) begin
            gap_tab[cfg_addr]  <= cfg_gap;
            kind_tab[cfg_addr] <= cfg_kind;
            data_tab[cfg_addr] <= cfg_exp_data;
            pc_tab[cfg_addr]   <= cfg_exp_pc;
            pen_tab[cfg_addr]  <= cfg_penalty;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A gap of 1 means "sample on the very next edge", so skip WAIT entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (num_clamped == '0) begin
                        state_nxt = DONE;
                    end else if (gap_first == 8'd1) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (gap_cnt <= 8'd2) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (last) begin
                    state_nxt = DONE;
                end else if (gap_next == 8'd1) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            gap_cnt    <= 8'd0;
            num_lat    <= '0;
            score      <= 16'd0;
            fail_count <= 8'd0;
        end else if (start_ok) begin
            idx        <= '0;
            gap_cnt    <= gap_first;
            num_lat    <= num_clamped;
            score      <= SCORE_INIT;
            fail_count <= 8'd0;
        end else if (state == WAIT) begin
            gap_cnt <= gap_cnt - 8'd1;
        end else if (state == CHECK) begin
            if (miss) begin
                score      <= (score > {8'd0, cur_pen}) ? (score - {8'd0, cur_pen}) : 16'd0;
                fail_count <= (fail_count == 8'hFF) ? fail_count : (fail_count + 8'd1);
            end
            if (!last) begin
                idx     <= idx_inc;
                gap_cnt <= gap_next;
            end
        end
    end

`ifdef WB_SCOREBOARD_FAILLOG_EN
    localparam int PW = $clog2(FAIL_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FAIL_DEPTH);

    logic [IW-1:0] fifo_mem [FAIL_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   fifo_cnt;
    logic          do_pop, do_push;

    assign fail_valid = (fifo_cnt != '0);
    assign fail_idx   = fail_valid ? fifo_mem[rd_ptr] : '0;
    assign do_pop     = fail_pop && fail_valid;
    // When full, a push only lands if the head is leaving on the same edge.
    assign do_push    = miss && ((fifo_cnt != FIFO_FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start_ok) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end
`else
    logic unused_fail_pop;
    assign unused_fail_pop = fail_pop;
    assign fail_valid      = 1'b0;
    assign fail_idx        = '0;
`endif

endmodule
